// File: rtl/pistormx_pkg.sv
// Shared constants for the 68K bus target: register offsets, FSM encoding, TX FIFO depth.
package pistormx_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_END  = 2'd3;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int TX_DEPTH = 4;

  // Bus cycle attributes captured at decode; uds/lds are active-high lane selects.
  typedef struct packed {
    logic [1:0] off;
    logic       rw;
    logic       uds;
    logic       lds;
  } bus_req_t;

  function automatic logic [15:0] lane_merge(input logic [15:0] d, input logic uds, input logic lds);
    return {uds ? d[15:8] : 8'h00, lds ? d[7:0] : 8'h00};
  endfunction

endpackage

// File: rtl/sync_fifo4x16.sv
// 4x16 TX FIFO: registered head, no read latency; push_rdy low when full (unless popping), pops on empty ignored.
module sync_fifo4x16
  import pistormx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_vld,
  input  logic [15:0] push_dat,
  output logic        push_rdy,
  input  logic        pop_vld,
  output logic [15:0] head_dat,
  output logic [2:0]  count,
  output logic        full,
  output logic        empty
);

  logic [15:0] mem [TX_DEPTH];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  cnt;
  logic        do_push, do_pop;

  assign full     = (cnt == 3'(TX_DEPTH));
  assign empty    = (cnt == 3'd0);
  assign do_pop   = pop_vld && !empty;
  assign push_rdy = !full || do_pop;
  assign do_push  = push_vld && push_rdy;
  assign head_dat = mem[rd_ptr];
  assign count    = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      cnt    <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/m68k_bus_target.sv
// 68K bus target with DATA/STATUS/CTRL registers; DTACK 2 sync + 1 decode + WAIT_STATES cycles after AS.
// Full TX FIFO drops the word (still acked, sets ovf); host RX load wins over a same-cycle 68K read.
module m68k_bus_target
  import pistormx_pkg::*;
#(
  parameter logic [7:0] BASE_HI     = 8'hE9,
  parameter int         WAIT_STATES = 2
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  inout  wire  [15:0] M68K_D,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  output wire         M68K_DTACK_n,
  output logic [15:0] HOST_RD_DATA,
  output logic        HOST_RD_VALID,
  input  logic        HOST_RD_POP,
  input  logic [15:0] HOST_WR_DATA,
  input  logic        HOST_WR_STB,
  output logic        HOST_IRQ
);

  logic [1:0]  as_sync, uds_sync, lds_sync, rw_sync;
  logic        as_s, uds_s, lds_s, rw_s;
  logic [1:0]  state;
  logic [7:0]  wait_cnt;
  bus_req_t    req;
  logic        sel, go_ack, in_ack, drive_bus, push_vld, push_rdy, ctrl_wr;
  logic [1:0]  off_now;
  logic [15:0] rd_mux, rd_dat_q, wr_dat, rx_dat_q;
  logic        rx_vld_q, irq_en_q, ovf_q;
  logic        fifo_full, fifo_empty;
  logic [2:0]  tx_count;
  logic        unused_addr;

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      as_sync  <= 2'b11;
      uds_sync <= 2'b11;
      lds_sync <= 2'b11;
      rw_sync  <= 2'b11;
    end else begin
      as_sync  <= {as_sync[0], M68K_AS_n};
      uds_sync <= {uds_sync[0], M68K_UDS_n};
      lds_sync <= {lds_sync[0], M68K_LDS_n};
      rw_sync  <= {rw_sync[0], M68K_RW};
    end
  end

  assign as_s  = as_sync[1];
  assign uds_s = uds_sync[1];
  assign lds_s = lds_sync[1];
  assign rw_s  = rw_sync[1];

  // Registers mirror across the whole 64 KiB window; only A[2:1] picks the register.
  assign unused_addr = ^M68K_A[15:3];
  assign sel     = !as_s && (M68K_A[23:16] == BASE_HI) && (!uds_s || !lds_s);
  assign off_now = (state == ST_IDLE) ? M68K_A[2:1] : req.off;
  assign go_ack  = (state == ST_IDLE && sel && WAIT_STATES == 0) ||
                   (state == ST_WAIT && !as_s && wait_cnt <= 8'd1);

  always_comb begin
    rd_mux = 16'h0000;
    case (off_now)
      REG_DATA:   rd_mux = rx_dat_q;
      REG_STATUS: rd_mux = {tx_count, fifo_full, rx_vld_q, 11'd0};
      REG_CTRL:   rd_mux = {ovf_q, 14'd0, irq_en_q};
      default:    rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 8'd0;
      req      <= '0;
      rd_dat_q <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: if (sel) begin
          req.off  <= M68K_A[2:1];
          req.rw   <= rw_s;
          req.uds  <= !uds_s;
          req.lds  <= !lds_s;
          wait_cnt <= 8'(WAIT_STATES);
          state    <= (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
        ST_WAIT: if (as_s) begin
          state <= ST_IDLE;
        end else begin
          wait_cnt <= wait_cnt - 8'd1;
          if (wait_cnt <= 8'd1) state <= ST_ACK;
        end
        ST_ACK:  state <= ST_END;
        default: if (as_s) state <= ST_IDLE;
      endcase
      // Read data is frozen on entry to ACK so D is stable through END.
      if (go_ack) rd_dat_q <= rd_mux;
    end
  end

  assign in_ack   = (state == ST_ACK);
  assign wr_dat   = lane_merge(M68K_D, req.uds, req.lds);
  assign push_vld = in_ack && !req.rw && (req.off == REG_DATA);
  assign ctrl_wr  = in_ack && !req.rw && (req.off == REG_CTRL);

  always_ff @(posedge M68K_CLK or negedge M68K_RESET_n) begin
    if (!M68K_RESET_n) begin
      rx_dat_q <= 16'h0000;
      rx_vld_q <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (HOST_WR_STB) begin
        rx_dat_q <= HOST_WR_DATA;
        rx_vld_q <= 1'b1;
      end else if (in_ack && req.rw && req.off == REG_DATA) begin
        rx_vld_q <= 1'b0;
      end
      if (ctrl_wr && req.lds) irq_en_q <= wr_dat[0];
      if (push_vld && !push_rdy)                ovf_q <= 1'b1;
      else if (ctrl_wr && req.uds && wr_dat[15]) ovf_q <= 1'b0;
    end
  end

  sync_fifo4x16 u_tx_fifo (
    .clk      (M68K_CLK),
    .rst_n    (M68K_RESET_n),
    .push_vld (push_vld),
    .push_dat (wr_dat),
    .push_rdy (push_rdy),
    .pop_vld  (HOST_RD_POP),
    .head_dat (HOST_RD_DATA),
    .count    (tx_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign drive_bus     = (state == ST_ACK) || (state == ST_END);
  assign M68K_DTACK_n  = drive_bus ? 1'b0 : 1'bz;
  assign M68K_D        = (drive_bus && req.rw) ? rd_dat_q : 16'bz;
  assign HOST_RD_VALID = !fifo_empty;
  assign HOST_IRQ      = irq_en_q && !fifo_empty;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Bench for m68k_bus_target: directed vector table, corner-case sequences, then random ops vs a queue model.
module tb_m68k_bus_target;

  localparam int WS  = 2;
  localparam int LAT = 3 + WS;  // two synchronizer flops, one decode cycle, then the wait states

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:1] a;
  logic        as_n, uds_n, lds_n, rw;
  logic [15:0] tb_d;
  logic        tb_d_oe;
  wire  [15:0] d_bus;
  wire         dtack_n;
  logic [15:0] host_rd_data, host_wr_data;
  logic        host_rd_valid, host_rd_pop, host_wr_stb, host_irq;

  always #5 clk = ~clk;
  assign d_bus = tb_d_oe ? tb_d : 16'bz;
  pullup (dtack_n);

  m68k_bus_target #(.BASE_HI(8'hE9), .WAIT_STATES(WS)) dut (
    .M68K_CLK     (clk),
    .M68K_RESET_n (rst_n),
    .M68K_A       (a),
    .M68K_D       (d_bus),
    .M68K_AS_n    (as_n),
    .M68K_UDS_n   (uds_n),
    .M68K_LDS_n   (lds_n),
    .M68K_RW      (rw),
    .M68K_DTACK_n (dtack_n),
    .HOST_RD_DATA (host_rd_data),
    .HOST_RD_VALID(host_rd_valid),
    .HOST_RD_POP  (host_rd_pop),
    .HOST_WR_DATA (host_wr_data),
    .HOST_WR_STB  (host_wr_stb),
    .HOST_IRQ     (host_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic bus_cycle(input bit wr, input logic [23:0] addr, input bit u, input bit l,
                           input logic [15:0] wd, input bit stb_at_ack, input logic [15:0] stb_dat,
                           output bit acked, output logic [15:0] rd_ack, output logic [15:0] rd_end);
    int n;
    acked = 1'b0; rd_ack = 16'h0; rd_end = 16'h0; n = 0;
    @(negedge clk);
    a = addr[23:1]; rw = !wr; uds_n = !u; lds_n = !l; tb_d = wd; tb_d_oe = wr; as_n = 1'b0;
    while (!acked && n < LAT + 3) begin
      @(negedge clk);
      n++;
      if (dtack_n === 1'b0) acked = 1'b1;
    end
    if (acked) begin
      check("ack_latency", 16'(n), 16'(LAT));
      rd_ack = d_bus;
      if (stb_at_ack) begin host_wr_data = stb_dat; host_wr_stb = 1'b1; end
      @(negedge clk);
      host_wr_stb = 1'b0;
      rd_end = d_bus;
      check("dtack_hold_end", 16'(dtack_n), 16'h0);
    end
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    if (acked) begin
      n = 0;
      while (dtack_n !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      check("dtack_release", 16'(dtack_n), 16'h1);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic reg_read(input string nm, input logic [23:0] addr, input logic [15:0] exp);
    bit ok; logic [15:0] r0, r1;
    bus_cycle(1'b0, addr, 1'b1, 1'b1, 16'h0, 1'b0, 16'h0, ok, r0, r1);
    check({nm, "_ack"}, 16'(ok), 16'h1);
    check({nm, "_d_ack"}, r0, exp);
    check({nm, "_d_end"}, r1, exp);
  endtask

  task automatic reg_write(input string nm, input logic [23:0] addr, input bit u, input bit l, input logic [15:0] d);
    bit ok; logic [15:0] r0, r1;
    bus_cycle(1'b1, addr, u, l, d, 1'b0, 16'h0, ok, r0, r1);
    check({nm, "_ack"}, 16'(ok), 16'h1);
  endtask

  task automatic host_pop();
    @(negedge clk); host_rd_pop = 1'b1;
    @(negedge clk); host_rd_pop = 1'b0;
  endtask

  task automatic host_load(input logic [15:0] v);
    @(negedge clk); host_wr_data = v; host_wr_stb = 1'b1;
    @(negedge clk); host_wr_stb = 1'b0;
  endtask

  // Behavioural model: TX FIFO as a queue, registers as plain variables.
  logic [15:0] mq[$];
  logic [15:0] m_rx;
  bit          m_rxv, m_irq, m_ovf;

  task automatic m_write(input int off, input bit u, input bit l, input logic [15:0] d);
    logic [15:0] w;
    w = {u ? d[15:8] : 8'h00, l ? d[7:0] : 8'h00};
    if (off == 0) begin
      if (mq.size() < 4) mq.push_back(w); else m_ovf = 1'b1;
    end else if (off == 2) begin
      if (l) m_irq = d[0];
      if (u && d[15]) m_ovf = 1'b0;
    end
  endtask

  task automatic m_read(input int off, output logic [15:0] r);
    logic [2:0] c;
    c = 3'(mq.size());
    case (off)
      0: begin r = m_rx; m_rxv = 1'b0; end
      1: r = {c, mq.size() == 4, m_rxv, 11'd0};
      2: r = {m_ovf, 14'd0, m_irq};
      default: r = 16'h0000;
    endcase
  endtask

  task automatic check_host(input string nm);
    check({nm, "_vld"}, 16'(host_rd_valid), 16'(mq.size() > 0));
    if (mq.size() > 0) check({nm, "_head"}, host_rd_data, mq[0]);
    check({nm, "_irq"}, 16'(host_irq), 16'(m_irq && mq.size() > 0));
  endtask

  typedef struct packed {
    bit          wr;
    logic [23:0] addr;
    bit          u, l;
    logic [15:0] wd;
    bit          ack;
    logic [15:0] rd;
    bit          vld;
    logic [15:0] head;
    bit          irq;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [23:0] ad, bit u, bit l, logic [15:0] wd,
                              bit ack, logic [15:0] rd, bit vld, logic [15:0] head, bit irq);
    return '{wr: wr, addr: ad, u: u, l: l, wd: wd, ack: ack, rd: rd, vld: vld, head: head, irq: irq};
  endfunction

  vec_t tbl[19];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    logic [15:0] r0, r1, exp;
    int n;

    tbl[0]  = mk(0, 24'hE90002, 1, 1, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[1]  = mk(0, 24'hE90004, 1, 1, 16'h0000, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[2]  = mk(1, 24'hE90004, 0, 1, 16'h00AB, 1, 16'h0000, 0, 16'h0000, 0);
    tbl[3]  = mk(0, 24'hE90004, 1, 1, 16'h0000, 1, 16'h0001, 0, 16'h0000, 0);
    tbl[4]  = mk(1, 24'hE90000, 1, 1, 16'h1234, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[5]  = mk(0, 24'hE90002, 1, 1, 16'h0000, 1, 16'h2000, 1, 16'h1234, 1);
    tbl[6]  = mk(1, 24'hE90000, 1, 0, 16'h5678, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[7]  = mk(1, 24'hE90000, 1, 1, 16'h1111, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[8]  = mk(1, 24'hE90000, 0, 1, 16'h22CD, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[9]  = mk(0, 24'hE90002, 1, 1, 16'h0000, 1, 16'h9000, 1, 16'h1234, 1);
    tbl[10] = mk(1, 24'hE90000, 1, 1, 16'h3333, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[11] = mk(0, 24'hE90004, 1, 1, 16'h0000, 1, 16'h8001, 1, 16'h1234, 1);
    tbl[12] = mk(0, 24'hE90002, 1, 1, 16'h0000, 1, 16'h9000, 1, 16'h1234, 1);
    tbl[13] = mk(1, 24'hE80000, 1, 1, 16'h4444, 0, 16'h0000, 1, 16'h1234, 1);
    tbl[14] = mk(0, 24'hE80002, 1, 1, 16'h0000, 0, 16'h0000, 1, 16'h1234, 1);
    tbl[15] = mk(1, 24'hE90006, 1, 1, 16'hFFFF, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[16] = mk(0, 24'hE90006, 1, 1, 16'h0000, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[17] = mk(1, 24'hE90004, 1, 0, 16'h8000, 1, 16'h0000, 1, 16'h1234, 1);
    tbl[18] = mk(0, 24'hE90004, 1, 1, 16'h0000, 1, 16'h0001, 1, 16'h1234, 1);

    rst_n = 1'b0; a = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; rw = 1'b1;
    tb_d = 16'h0; tb_d_oe = 1'b0; host_rd_pop = 1'b0; host_wr_data = 16'h0; host_wr_stb = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dtack", 16'(dtack_n), 16'h1);
    check("reset_vld", 16'(host_rd_valid), 16'h0);
    check("reset_irq", 16'(host_irq), 16'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 19; i++) begin
      bus_cycle(tbl[i].wr, tbl[i].addr, tbl[i].u, tbl[i].l, tbl[i].wd, 1'b0, 16'h0, ok, r0, r1);
      check($sformatf("vec%0d_ack", i), 16'(ok), 16'(tbl[i].ack));
      if (!tbl[i].wr && tbl[i].ack) begin
        check($sformatf("vec%0d_rd_ack", i), r0, tbl[i].rd);
        check($sformatf("vec%0d_rd_end", i), r1, tbl[i].rd);
      end
      check($sformatf("vec%0d_vld", i), 16'(host_rd_valid), 16'(tbl[i].vld));
      if (tbl[i].vld) check($sformatf("vec%0d_head", i), host_rd_data, tbl[i].head);
      check($sformatf("vec%0d_irq", i), 16'(host_irq), 16'(tbl[i].irq));
    end

    // Drain: order kept, byte pushes zero-filled, the overflowed fifth word absent.
    host_pop(); check("drain1", host_rd_data, 16'h5600);
    host_pop(); check("drain2", host_rd_data, 16'h1111);
    host_pop(); check("drain3", host_rd_data, 16'h00CD);
    host_pop(); check("drain_empty", 16'(host_rd_valid), 16'h0);
    host_pop(); check("pop_empty", 16'(host_rd_valid), 16'h0);
    check("irq_empty", 16'(host_irq), 16'h0);
    reg_read("status_empty", 24'hE90002, 16'h0000);

    host_load(16'hBEEF);
    reg_read("status_rxv", 24'hE90002, 16'h0800);
    reg_read("rx_read", 24'hE90000, 16'hBEEF);
    reg_read("status_rx_clr", 24'hE90002, 16'h0000);
    reg_read("rx_reread", 24'hE90000, 16'hBEEF);

    // Host load coincident with the DATA read action: load wins, rx_valid stays set.
    host_load(16'h1111);
    bus_cycle(1'b0, 24'hE90000, 1'b1, 1'b1, 16'h0, 1'b1, 16'hCAFE, ok, r0, r1);
    check("prio_ack", 16'(ok), 16'h1);
    check("prio_rd", r0, 16'h1111);
    reg_read("prio_status", 24'hE90002, 16'h0800);
    reg_read("prio_rx", 24'hE90000, 16'hCAFE);

    // AS released while the FSM sits in WAIT.
    @(negedge clk);
    a = 23'h748000; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; tb_d = 16'h7777; tb_d_oe = 1'b1; as_n = 1'b0;
    repeat (2) @(negedge clk);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    ok = 1'b0;
    repeat (8) begin @(negedge clk); if (dtack_n === 1'b0) ok = 1'b1; end
    check("abort_no_ack", 16'(ok), 16'h0);
    check("abort_no_push", 16'(host_rd_valid), 16'h0);
    reg_read("abort_status", 24'hE90002, 16'h0000);

    // Reset pulsed while END holds the bus.
    @(negedge clk);
    a = 23'h748000; rw = 1'b0; uds_n = 1'b0; lds_n = 1'b0; tb_d = 16'h5555; tb_d_oe = 1'b1; as_n = 1'b0;
    n = 0;
    while (dtack_n !== 1'b0 && n < LAT + 3) begin @(negedge clk); n++; end
    check("rst_seq_ack", 16'(dtack_n), 16'h0);
    @(negedge clk);
    check("rst_seq_push", host_rd_data, 16'h5555);
    check("rst_seq_irq", 16'(host_irq), 16'h1);
    rst_n = 1'b0;
    #1;
    check("rst_dtack_release", 16'(dtack_n), 16'h1);
    check("rst_fifo_empty", 16'(host_rd_valid), 16'h0);
    check("rst_irq", 16'(host_irq), 16'h0);
    as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1; tb_d_oe = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    reg_read("rst_ctrl", 24'hE90004, 16'h0000);
    reg_read("rst_status", 24'hE90002, 16'h0000);

    mq.delete(); m_irq = 1'b0; m_ovf = 1'b0;
    host_load(16'h0F0F); m_rx = 16'h0F0F; m_rxv = 1'b1;

    for (int k = 0; k < 150; k++) begin
      int op, off, ln;
      logic [15:0] d;
      logic [23:0] ad;
      op = $urandom_range(0, 9);
      off = $urandom_range(0, 3);
      ln = $urandom_range(1, 3);
      d = 16'($urandom);
      ad = {8'hE9, 13'($urandom), 2'(off), 1'b0};
      if (op <= 3) begin
        bus_cycle(1'b1, ad, ln[1], ln[0], d, 1'b0, 16'h0, ok, r0, r1);
        check("rnd_wr_ack", 16'(ok), 16'h1);
        m_write(off, ln[1], ln[0], d);
      end else if (op <= 6) begin
        bus_cycle(1'b0, ad, ln[1], ln[0], 16'h0, 1'b0, 16'h0, ok, r0, r1);
        m_read(off, exp);
        check("rnd_rd_ack", 16'(ok), 16'h1);
        check($sformatf("rnd_rd_off%0d", off), r0, exp);
        check($sformatf("rnd_rd_end_off%0d", off), r1, exp);
      end else if (op == 7) begin
        host_load(d);
        m_rx = d; m_rxv = 1'b1;
      end else if (op == 8) begin
        host_pop();
        if (mq.size() > 0) void'(mq.pop_front());
      end else begin
        ad[23:16] = 8'($urandom);
        if (ad[23:16] == 8'hE9) ad[23:16] = 8'hE8;
        bus_cycle(1'b1, ad, 1'b1, 1'b1, d, 1'b0, 16'h0, ok, r0, r1);
        check("rnd_miss_ack", 16'(ok), 16'h0);
      end
      check_host($sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m68k_bus_target.md
M68K_BUS_TARGET -- requirements
Module: m68k_bus_target

Interface
REQ-001 Parameter BASE_HI, default 8'hE9, is the A[23:16] match value that selects the 64 KiB target window.
REQ-002 Parameter WAIT_STATES, default 2, is the number of M68K_CLK cycles inserted between decode and DTACK.
REQ-003 M68K_CLK  input  1  is the sole clock; all state updates on its rising edge.
REQ-004 M68K_RESET_n  input  1  is the asynchronous, active-low reset.
REQ-005 M68K_A  input  23  is the address bus A[23:1].
REQ-006 M68K_D  inout  16  is the data bus; driven only during an acknowledged read of this target.
REQ-007 M68K_AS_n, M68K_UDS_n, M68K_LDS_n, M68K_RW  input  1 each  are the strobes from the bus master.
REQ-008 M68K_DTACK_n  output  1  is the acknowledge; 1'bz when not acknowledging.
REQ-009 HOST_RD_DATA  output  16  is the head of the TX FIFO.
REQ-010 HOST_RD_VALID  output  1  means the TX FIFO is non-empty.
REQ-011 HOST_RD_POP  input  1  pops one TX FIFO entry when HOST_RD_VALID is high.
REQ-012 HOST_WR_DATA  input  16  and HOST_WR_STB  input  1  load the RX holding register.
REQ-013 HOST_IRQ  output  1  is high while CTRL.irq_en=1 and the TX FIFO is non-empty.

Function
REQ-014 AS_n, UDS_n, LDS_n and RW SHALL pass through a 2-flop synchronizer; A and D are sampled only while synchronized AS is low.
REQ-015 A cycle selects this target when AS_n is low, A[23:16]==BASE_HI and at least one DS is low.
REQ-016 Register map (A[2:1]): 0=DATA (write pushes TX FIFO, read returns RX and clears rx_valid), 1=STATUS {tx_count[2:0], tx_full, rx_valid, 11'd0}, 2=CTRL (bit0 irq_en, read/write), 3=reads 16'h0, writes ignored.
REQ-017 FSM states: IDLE, WAIT, ACK, END.
REQ-018 IDLE->WAIT on a selection; the wait counter loads WAIT_STATES; IDLE->ACK directly when WAIT_STATES=0.
REQ-019 WAIT decrements each cycle and goes ->ACK at 0; ACK performs the register action exactly once, drives DTACK_n=0, then goes ->END.
REQ-020 END holds DTACK_n=0, and D on reads, until synchronized AS_n goes high; it then releases DTACK and D to 1'bz and returns to IDLE.
REQ-021 Byte writes update only the selected lane (UDS=D[15:8], LDS=D[7:0]); FIFO pushes store the full 16-bit word with the unselected lane as 0.
REQ-022 TX FIFO depth is 4 with 2-bit wrapping pointers and a 3-bit count; a push when full is dropped but still acknowledged, and sets a sticky ovf flag in CTRL bit15, cleared by writing 1.
REQ-023 A pop when empty is ignored; a push and pop in the same cycle leave the count unchanged.
REQ-024 HOST_WR_STB in the same cycle as a 68K DATA read gives priority to the host load, leaving rx_valid=1.
REQ-025 If AS_n rises during WAIT, the FSM aborts to IDLE with no register side effect and no DTACK.
REQ-026 Reads from an empty RX return its last value with rx_valid=0.

Reset
REQ-027 Reset SHALL place the FSM in IDLE, DTACK_n and D at 1'bz, the FIFO empty (pointers 0), rx_valid=0, CTRL=0, HOST_IRQ=0 and the synchronizers all at 1.
REQ-028 A reset asserted mid-cycle SHALL release the bus immediately and discard any pending register action.

Structure
REQ-029 The register offsets, the FSM state encoding and the FIFO depth constant SHALL live in the shared package pistormx_pkg.
REQ-030 The TX FIFO SHALL be a separate sub-module, sync_fifo4x16.

Verification
REQ-031 Word write 16'h1234 to E90000 with WAIT_STATES=2 -> DTACK_n low 2 cycles after decode, and HOST_RD_DATA=16'h1234 with HOST_RD_VALID=1.
REQ-032 Five writes without a pop -> tx_count=4, tx_full=1, ovf=1, and the fifth word absent.
REQ-033 Host loads 16'hBEEF, then a 68K read of DATA -> D=16'hBEEF during ACK/END, and STATUS afterwards has rx_valid=0.
REQ-034 A byte write via LDS only of 16'h00AB to CTRL -> irq_en=1, and HOST_IRQ rises once the FIFO is non-empty.
REQ-035 AS_n raised during WAIT, or a cycle to A[23:16]=8'hE8 -> no DTACK, and registers unchanged.
REQ-036 Reset pulsed during END -> DTACK_n=1'bz within 1 cycle, FIFO empty, and CTRL=0.
